// File: rtl/rf_io_ctrl.sv
// rtl/rf_io_ctrl.sv - SPI-addressed I/O control/status registers with RF front-end mode decode
//
// Ports:
//   i_sys_clk, i_reset          clock, asynchronous active-high reset
//   i_ioc, i_data_in            register address and write data from spi_if
//   o_data_out                  registered read data to spi_if
//   i_cs, i_fetch_cmd, i_load_cmd  module select, read strobe, write strobe
//   i_button, i_config          asynchronous board inputs (synchronized internally)
//   o_led0, o_led1, o_pmod      LED and PMOD drives
//   o_mixer_en, o_mixer_fm      mixer control
//   o_rx_h_tx_l(_b), o_tr_vc1(_b), o_tr_vc2, o_shdn_rx_lna, o_shdn_tx_lna  RF front-end lines

module rf_io_ctrl #(
    parameter logic [7:0] MODULE_VERSION = 8'h01,
    parameter logic [7:0] PMOD_RST       = 8'h00
) (
    input  logic       i_sys_clk,
    input  logic       i_reset,
    input  logic [4:0] i_ioc,
    input  logic [7:0] i_data_in,
    output logic [7:0] o_data_out,
    input  logic       i_cs,
    input  logic       i_fetch_cmd,
    input  logic       i_load_cmd,
    input  logic       i_button,
    input  logic [3:0] i_config,
    output logic       o_led0,
    output logic       o_led1,
    output logic [7:0] o_pmod,
    output logic       o_mixer_en,
    output logic       o_mixer_fm,
    output logic       o_rx_h_tx_l,
    output logic       o_rx_h_tx_l_b,
    output logic       o_tr_vc1,
    output logic       o_tr_vc1_b,
    output logic       o_tr_vc2,
    output logic       o_shdn_rx_lna,
    output logic       o_shdn_tx_lna
);

    localparam logic [4:0] IOC_VERSION = 5'h00;
    localparam logic [4:0] IOC_LED     = 5'h01;
    localparam logic [4:0] IOC_PMOD    = 5'h02;
    localparam logic [4:0] IOC_RF_MODE = 5'h03;
    localparam logic [4:0] IOC_MIXER   = 5'h04;
    localparam logic [4:0] IOC_STATUS  = 5'h05;

    // {rx_h_tx_l, tr_vc1, tr_vc2, shdn_rx, shdn_tx}
    localparam logic [4:0] RF_LOW_PWR = 5'b10011;

    logic [1:0] led_reg;
    logic [7:0] pmod_reg;
    logic [2:0] rf_mode_reg;
    logic [1:0] mixer_reg;
    logic [4:0] rf_bits;
    logic       button_meta, button_sync;
    logic [3:0] config_meta, config_sync;
    logic [7:0] rd_data;
    logic       wr_en;
    logic       rd_en;

    assign wr_en = i_cs & i_load_cmd;
    assign rd_en = i_cs & i_fetch_cmd;

    function automatic logic [4:0] rf_decode(input logic [2:0] mode);
        case (mode)
            3'd1:    rf_decode = 5'b11001;  // RX_LP
            3'd2:    rf_decode = 5'b10101;  // RX_HP
            3'd3:    rf_decode = 5'b01010;  // TX_LP
            3'd4:    rf_decode = 5'b00110;  // TX_HP
            3'd5:    rf_decode = 5'b11111;  // BYPASS
            default: rf_decode = RF_LOW_PWR; // 0, and reserved 6/7 fail safe
        endcase
    endfunction

    // Read mux sees pre-write register values, so load+fetch returns old data.
    always_comb begin
        rd_data = 8'h00;
        case (i_ioc)
            IOC_VERSION: rd_data = MODULE_VERSION;
            IOC_LED:     rd_data = {6'b0, led_reg};
            IOC_PMOD:    rd_data = pmod_reg;
            IOC_RF_MODE: rd_data = {5'b0, rf_mode_reg};
            IOC_MIXER:   rd_data = {6'b0, mixer_reg};
            IOC_STATUS:  rd_data = {3'b0, button_sync, config_sync};
            default:     rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            led_reg     <= 2'b00;
            pmod_reg    <= PMOD_RST;
            rf_mode_reg <= 3'd0;
            mixer_reg   <= 2'b00;
            rf_bits     <= RF_LOW_PWR;
            o_data_out  <= 8'h00;
            button_meta <= 1'b0;
            button_sync <= 1'b0;
            config_meta <= 4'h0;
            config_sync <= 4'h0;
        end else begin
            button_meta <= i_button;
            button_sync <= button_meta;
            config_meta <= i_config;
            config_sync <= config_meta;

            if (rd_en) begin
                o_data_out <= rd_data;
            end

            if (wr_en) begin
                case (i_ioc)
                    IOC_LED:  led_reg  <= i_data_in[1:0];
                    IOC_PMOD: pmod_reg <= i_data_in;
                    IOC_RF_MODE: begin
                        rf_mode_reg <= i_data_in[2:0];
                        // Decode registered alongside the mode so switch lines never glitch.
                        rf_bits     <= rf_decode(i_data_in[2:0]);
                    end
                    IOC_MIXER: mixer_reg <= i_data_in[1:0];
                    default: ;
                endcase
            end
        end
    end

    assign o_led0        = led_reg[0];
    assign o_led1        = led_reg[1];
    assign o_pmod        = pmod_reg;
    assign o_mixer_en    = mixer_reg[0];
    assign o_mixer_fm    = mixer_reg[1];
    assign o_rx_h_tx_l   = rf_bits[4];
    assign o_tr_vc1      = rf_bits[3];
    assign o_tr_vc2      = rf_bits[2];
    assign o_shdn_rx_lna = rf_bits[1];
    assign o_shdn_tx_lna = rf_bits[0];
    // Complements taken straight from the register bits so they track through reset too.
    assign o_rx_h_tx_l_b = ~rf_bits[4];
    assign o_tr_vc1_b    = ~rf_bits[3];

endmodule

// File: tb/tb_rf_io_ctrl.sv
// tb/tb_rf_io_ctrl.sv - self-checking bench for rf_io_ctrl

module tb_rf_io_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ioc = 5'h00;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       cs = 1'b0;
    logic       fetch = 1'b0;
    logic       load = 1'b0;
    logic       button = 1'b0;
    logic [3:0] cfg = 4'h0;
    logic       led0, led1, mix_en, mix_fm;
    logic [7:0] pmod;
    logic       rx, rx_b, vc1, vc1_b, vc2, shrx, shtx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_io_ctrl dut (
        .i_sys_clk     (clk),
        .i_reset       (rst),
        .i_ioc         (ioc),
        .i_data_in     (din),
        .o_data_out    (dout),
        .i_cs          (cs),
        .i_fetch_cmd   (fetch),
        .i_load_cmd    (load),
        .i_button      (button),
        .i_config      (cfg),
        .o_led0        (led0),
        .o_led1        (led1),
        .o_pmod        (pmod),
        .o_mixer_en    (mix_en),
        .o_mixer_fm    (mix_fm),
        .o_rx_h_tx_l   (rx),
        .o_rx_h_tx_l_b (rx_b),
        .o_tr_vc1      (vc1),
        .o_tr_vc1_b    (vc1_b),
        .o_tr_vc2      (vc2),
        .o_shdn_rx_lna (shrx),
        .o_shdn_tx_lna (shtx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] rf_tuple();
        return {rx, vc1, vc2, shrx, shtx};
    endfunction

    // Behavioural model: register file contents, read-back and synchronizer history.
    logic [1:0] m_led;
    logic [7:0] m_pmod;
    logic [2:0] m_mode;
    logic [1:0] m_mix;
    logic [7:0] m_dout;
    logic [4:0] m_hist0, m_hist1;  // {button,config} sampled 1 and 2 edges back
    logic [4:0] tuple_tab [8];

    initial begin
        tuple_tab[0] = 5'b10011;
        tuple_tab[1] = 5'b11001;
        tuple_tab[2] = 5'b10101;
        tuple_tab[3] = 5'b01010;
        tuple_tab[4] = 5'b00110;
        tuple_tab[5] = 5'b11111;
        tuple_tab[6] = 5'b10011;
        tuple_tab[7] = 5'b10011;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_led = 0; m_pmod = 0; m_mode = 0; m_mix = 0; m_dout = 0;
            m_hist0 = 0; m_hist1 = 0;
        end else begin
            if (cs && fetch) begin
                if (ioc == 5'd0)      m_dout = 8'h01;
                else if (ioc == 5'd1) m_dout = 8'(m_led);
                else if (ioc == 5'd2) m_dout = m_pmod;
                else if (ioc == 5'd3) m_dout = 8'(m_mode);
                else if (ioc == 5'd4) m_dout = 8'(m_mix);
                else if (ioc == 5'd5) m_dout = 8'(m_hist1);
                else                  m_dout = 8'h00;
            end
            if (cs && load) begin
                if (ioc == 5'd1) m_led  = din[1:0];
                if (ioc == 5'd2) m_pmod = din;
                if (ioc == 5'd3) m_mode = din[2:0];
                if (ioc == 5'd4) m_mix  = din[1:0];
            end
            m_hist1 = m_hist0;
            m_hist0 = {button, cfg};
        end
    end

    // Single compare process: every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("model_dout", dout, m_dout);
            check("model_leds", {led1, led0}, m_led);
            check("model_pmod", pmod, m_pmod);
            check("model_mixer", {mix_fm, mix_en}, m_mix);
            check("model_rf", rf_tuple(), tuple_tab[m_mode]);
            check("model_cmpl", {rx_b, vc1_b}, {~rx, ~vc1});
        end
    end

    // One strobe cycle: inputs change 1 unit after a rising edge, held over the next edge.
    task automatic cmd(input logic [4:0] a, input logic [7:0] d,
                       input logic ld, input logic fe, input logic sel);
        @(posedge clk); #1;
        ioc = a; din = d; load = ld; fetch = fe; cs = sel;
        @(posedge clk); #1;
        load = 0; fetch = 0; cs = 0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_leds", {led1, led0}, 2'b00);
        check("rst_pmod", pmod, 8'h00);
        check("rst_rf", rf_tuple(), 5'b10011);
        check("rst_rx_b", rx_b, 1'b0);
        check("rst_mixer", {mix_fm, mix_en}, 2'b00);
        rst = 0;

        cmd(5'h01, 8'h03, 1, 0, 1);
        cmd(5'h01, 8'h00, 0, 1, 1);
        check("led_on", {led1, led0}, 2'b11);
        check("led_read", dout, 8'h03);
        cmd(5'h00, 8'h00, 0, 1, 1);
        check("version", dout, 8'h01);

        cmd(5'h03, 8'h01, 1, 0, 1); check("rf_mode1", rf_tuple(), 5'b11001);
        cmd(5'h03, 8'h02, 1, 0, 1); check("rf_mode2", rf_tuple(), 5'b10101);
        cmd(5'h03, 8'h03, 1, 0, 1); check("rf_mode3", rf_tuple(), 5'b01010);
        cmd(5'h03, 8'h04, 1, 0, 1); check("rf_mode4", rf_tuple(), 5'b00110);
        cmd(5'h03, 8'h05, 1, 0, 1); check("rf_mode5", rf_tuple(), 5'b11111);
        cmd(5'h03, 8'h07, 1, 0, 1); check("rf_mode7", rf_tuple(), 5'b10011);
        cmd(5'h03, 8'h00, 0, 1, 1); check("rf_mode7_read", dout, 8'h07);

        cmd(5'h04, 8'h03, 1, 0, 1); check("mixer_on", {mix_fm, mix_en}, 2'b11);
        cmd(5'h00, 8'hFF, 1, 0, 1); check("ro_write", pmod, 8'h00);

        cmd(5'h02, 8'hAA, 1, 0, 0); check("pmod_nocs", pmod, 8'h00);
        cmd(5'h02, 8'hAA, 1, 0, 1); check("pmod_aa", pmod, 8'hAA);
        cmd(5'h02, 8'h55, 1, 1, 1);
        check("ldfe_dout", dout, 8'hAA);
        check("ldfe_pmod", pmod, 8'h55);

        cfg = 4'hA; button = 1;
        repeat (3) @(posedge clk);
        cmd(5'h05, 8'h00, 0, 1, 1); check("status", dout, 8'h1A);
        cmd(5'h1F, 8'h00, 0, 1, 1); check("unmapped", dout, 8'h00);

        // Reset asserted mid-write while in TX_HP, between clock edges.
        cmd(5'h03, 8'h04, 1, 0, 1); check("txhp", rf_tuple(), 5'b00110);
        @(posedge clk); #1;
        ioc = 5'h02; din = 8'h77; load = 1; cs = 1;
        #2 rst = 1;
        #1;
        check("async_rf", rf_tuple(), 5'b10011);
        check("async_cmpl", {rx_b, vc1_b}, 2'b01);
        check("async_pmod", pmod, 8'h00);
        check("async_dout", dout, 8'h00);
        @(posedge clk); #1;
        check("rst_strobe", pmod, 8'h00);
        load = 0; cs = 0;
        @(negedge clk); rst = 0;
        cmd(5'h03, 8'h00, 0, 1, 1); check("post_rst_mode", dout, 8'h00);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
